// File: rtl/seq_sync_tx_if.sv
// seq_sync_tx_if: payload handshake between a word producer and the
// sync-frame transmitter.
//   in_valid  producer offers a payload word
//   in_ready  transmitter can accept a word this cycle
//   in_data   payload word, sampled on accept
// Modports: master = producer side, slave = transmitter side.
interface seq_sync_tx_if #(
  parameter int NBITS = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_sync_tx.sv
// seq_sync_tx: serial sync-frame transmitter.
// Each accepted payload word is sent as the marker 1,0,1, then the payload
// MSB-first, then two guard zeros, followed by at least one idle cycle.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   bus        slave side of the payload handshake (in_valid/in_ready/in_data)
//   out        serial line bit
//   out_valid  high while a frame is in progress (SYNC, DATA or GAP)
//   state      one-hot FSM state for debug: IDLE=0001 SYNC=0010 DATA=0100 GAP=1000
module seq_sync_tx #(
  parameter int NBITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  seq_sync_tx_if.slave        bus,
  output logic                out,
  output logic                out_valid,
  output logic [3:0]          state
);

  // The counter must also reach 2 in SYNC, so it never drops below 2 bits
  // even when $clog2(NBITS+1) would give 1 (NBITS=1).
  localparam int CW = ($clog2(NBITS + 1) < 2) ? 2 : $clog2(NBITS + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(2);
  localparam logic [CW-1:0] DATA_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(1);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SYNC = 4'b0010,
    DATA = 4'b0100,
    GAP  = 4'b1000
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NBITS-1:0] shift_reg, shift_next;
  logic             out_bit;
  logic             busy;
  logic             ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    out_bit    = 1'b0;
    busy       = 1'b0;
    ready      = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          shift_next = bus.in_data;
          cnt_next   = '0;
          state_next = SYNC;
        end
      end

      SYNC: begin
        busy    = 1'b1;
        // Marker 1,0,1: only the middle count drives a zero.
        out_bit = (cnt_reg != CNT_ONE);
        if (cnt_reg == SYNC_LAST) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        busy       = 1'b1;
        out_bit    = shift_reg[NBITS-1];
        shift_next = shift_reg << 1;
        if (cnt_reg == DATA_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      GAP: begin
        busy = 1'b1;
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        // Corrupted encoding: recover to IDLE with all outputs quiet.
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready = ready;
  assign out          = out_bit;
  assign out_valid    = busy;
  assign state        = state_reg;

endmodule
